// File: rtl/calc_pkg.sv
// Shared constants, FSM encoding and packed-BCD digit helpers for the
// calc_seq sequential BCD calculator.
package calc_pkg;

  localparam int NDIG   = 5;
  localparam int WORD_W = 21;
  localparam int MAG_W  = 4 * NDIG;

  localparam logic [3:0] OP_ADD = 4'd10;
  localparam logic [3:0] OP_SUB = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_DIV = 4'd13;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SETUP     = 4'd1,
    ADDSUB    = 4'd2,
    MUL_SHIFT = 4'd3,
    MUL_ADD   = 4'd4,
    DIV_SHIFT = 4'd5,
    DIV_CMP   = 4'd6,
    DIV_SUB   = 4'd7,
    DONE      = 4'd8
  } state_t;

  function automatic logic [3:0] get_dig(logic [MAG_W-1:0] v, logic [2:0] i);
    logic [3:0] d;
    d = 4'd0;
    for (int k = 0; k < NDIG; k++) begin
      if (i == 3'(k)) d = v[4*k +: 4];
    end
    return d;
  endfunction

  function automatic logic [MAG_W-1:0] set_dig(logic [MAG_W-1:0] v, logic [2:0] i,
                                               logic [3:0] d);
    logic [MAG_W-1:0] r;
    r = v;
    for (int k = 0; k < NDIG; k++) begin
      if (i == 3'(k)) r[4*k +: 4] = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single BCD digit adder/subtractor; the one digit arithmetic unit that all
// calculator operations time-share.
module bcd_digit_addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] y,
  output logic       cout
);

  logic [4:0] sum;
  logic [4:0] need;

  always_comb begin
    y    = 4'd0;
    cout = 1'b0;
    sum  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    need = {1'b0, b} + {4'd0, cin};
    if (!sub) begin
      if (sum > 5'd9) begin
        y    = 4'(sum - 5'd10);
        cout = 1'b1;
      end else begin
        y = sum[3:0];
      end
    end else begin
      // cin/cout act as borrow-in/borrow-out when subtracting
      if ({1'b0, a} >= need) begin
        y = 4'({1'b0, a} - need);
      end else begin
        y    = 4'({1'b0, a} + 5'd10 - need);
        cout = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_seq.sv
// Sequential signed-BCD calculator (add/sub/mul/div) built around one
// digit-serial BCD add/sub unit.
module calc_seq
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [20:0] BCDa,
  input  logic [20:0] BCDb,
  input  logic [3:0]  opcode,
  input  logic        start,
  output logic [20:0] result,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  dbg_state
);

  // Handshake: start is taken only while idle (busy low); busy rises the
  // cycle after and falls on the edge that raises the one-cycle done pulse.
  state_t            state_q, state_d;
  logic [20:0]       a_q, a_d, b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [MAG_W-1:0]  acc_q, acc_d, opnd_q, opnd_d, src_q, src_d, quo_q, quo_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        dig_q, dig_d, pos_q, pos_d;
  logic              carry_q, carry_d, sub_q, sub_d, sign_q, sign_d;
  logic              ovf_q, ovf_d, ferr_q, ferr_d;
  logic [20:0]       result_q, result_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [3:0]        u_a, u_b, u_y;
  logic              u_cin, u_sub, u_co;
  logic [MAG_W-1:0]  ma, mb, mag;
  logic              sa, sb, sbe, last_dig, fail;

  assign sa  = a_q[20];
  assign sb  = b_q[20];
  assign ma  = a_q[MAG_W-1:0];
  assign mb  = b_q[MAG_W-1:0];
  assign sbe = sb ^ (op_q == OP_SUB);
  assign last_dig = (dig_q == 3'(NDIG-1));

  always_comb begin
    u_a   = get_dig(acc_q, dig_q);
    u_b   = get_dig(opnd_q, dig_q);
    u_cin = (dig_q != 3'd0) && carry_q;
    u_sub = (state_q == DIV_SUB) || ((state_q == ADDSUB) && sub_q);
  end

  bcd_digit_addsub u_digit (
    .a    (u_a),
    .b    (u_b),
    .cin  (u_cin),
    .sub  (u_sub),
    .y    (u_y),
    .cout (u_co)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    src_d    = src_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    dig_d    = dig_q;
    pos_d    = pos_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    ferr_d   = ferr_q;
    result_d = result_q;
    err_d    = err_q;
    mag      = (op_q == OP_DIV) ? quo_q : acc_q;
    fail     = ferr_q || ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = BCDa;
          b_d     = BCDb;
          op_d    = opcode;
          ovf_d   = 1'b0;
          ferr_d  = 1'b0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        dig_d   = 3'd0;
        carry_d = 1'b0;
        pos_d   = 3'(NDIG-1);
        cnt_d   = 4'd0;
        quo_d   = '0;
        sign_d  = sa ^ sb;
        case (op_q)
          OP_ADD, OP_SUB: begin
            // Larger magnitude goes first so subtraction never borrows out
            sub_d   = (sa != sbe);
            state_d = ADDSUB;
            if (sa == sbe || ma >= mb) begin
              acc_d  = ma;
              opnd_d = mb;
              sign_d = sa;
            end else begin
              acc_d  = mb;
              opnd_d = ma;
              sign_d = sbe;
            end
          end
          OP_MUL: begin
            acc_d   = '0;
            opnd_d  = ma;
            src_d   = mb;
            state_d = MUL_SHIFT;
          end
          OP_DIV: begin
            acc_d  = '0;
            opnd_d = mb;
            src_d  = ma;
            if (mb == '0) begin
              ferr_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = DIV_SHIFT;
            end
          end
          default: begin
            ferr_d  = 1'b1;
            state_d = DONE;
          end
        endcase
      end

      ADDSUB: begin
        acc_d   = set_dig(acc_q, dig_q, u_y);
        carry_d = u_co;
        if (last_dig) begin
          if (!sub_q && u_co) ovf_d = 1'b1;
          state_d = DONE;
        end else begin
          dig_d = dig_q + 3'd1;
        end
      end

      MUL_SHIFT: begin
        if (acc_q[MAG_W-1 -: 4] != 4'd0) ovf_d = 1'b1;
        acc_d   = {acc_q[MAG_W-5:0], 4'd0};
        cnt_d   = get_dig(src_q, pos_q);
        dig_d   = 3'd0;
        carry_d = 1'b0;
        if (get_dig(src_q, pos_q) != 4'd0) begin
          state_d = MUL_ADD;
        end else if (pos_q == 3'd0) begin
          state_d = DONE;
        end else begin
          pos_d = pos_q - 3'd1;
        end
      end

      MUL_ADD: begin
        acc_d   = set_dig(acc_q, dig_q, u_y);
        carry_d = u_co;
        if (last_dig) begin
          if (u_co) ovf_d = 1'b1;
          cnt_d = cnt_q - 4'd1;
          dig_d = 3'd0;
          if (cnt_q == 4'd1) begin
            if (pos_q == 3'd0) begin
              state_d = DONE;
            end else begin
              pos_d   = pos_q - 3'd1;
              state_d = MUL_SHIFT;
            end
          end
        end else begin
          dig_d = dig_q + 3'd1;
        end
      end

      DIV_SHIFT: begin
        // Remainder never exceeds the dividend prefix, so five digits suffice
        acc_d   = {acc_q[MAG_W-5:0], get_dig(src_q, pos_q)};
        cnt_d   = 4'd0;
        state_d = DIV_CMP;
      end

      DIV_CMP: begin
        dig_d   = 3'd0;
        carry_d = 1'b0;
        if (acc_q >= opnd_q) begin
          state_d = DIV_SUB;
        end else begin
          quo_d = set_dig(quo_q, pos_q, cnt_q);
          if (pos_q == 3'd0) begin
            state_d = DONE;
          end else begin
            pos_d   = pos_q - 3'd1;
            state_d = DIV_SHIFT;
          end
        end
      end

      DIV_SUB: begin
        acc_d   = set_dig(acc_q, dig_q, u_y);
        carry_d = u_co;
        if (last_dig) begin
          cnt_d   = cnt_q + 4'd1;
          state_d = DIV_CMP;
        end else begin
          dig_d = dig_q + 3'd1;
        end
      end

      DONE: begin
        err_d    = fail;
        result_d = fail ? '0 : {(mag != '0) && sign_q, mag};
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    done_d = (state_q == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      src_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      dig_q    <= '0;
      pos_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      src_q    <= src_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      pos_q    <= pos_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign result    = result_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq: integer reference model, directed vectors,
// control scenarios and randomized operations.
module tb_calc_seq;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] BCDa = '0;
  logic [20:0] BCDb = '0;
  logic [3:0]  opcode = '0;
  logic        start = 1'b0;
  logic [20:0] result;
  logic        busy, done, err;
  logic [3:0]  dbg_state;

  calc_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .BCDa      (BCDa),
    .BCDb      (BCDb),
    .opcode    (opcode),
    .start     (start),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  logic [21:0] exp_q[$];
  int          lat_q[$];

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint bcd2int(logic [19:0] v);
    longint r = 0;
    for (int k = 4; k >= 0; k--) r = r * 10 + longint'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [19:0] int2bcd(longint m);
    logic [19:0] v = '0;
    for (int k = 0; k < 5; k++) begin
      v[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return v;
  endfunction

  // returns {err, result}
  function automatic logic [21:0] model(logic [20:0] a, logic [20:0] b, logic [3:0] op);
    longint va, vb, r;
    bit bad;
    va = bcd2int(a[19:0]);
    vb = bcd2int(b[19:0]);
    if (a[20]) va = -va;
    if (b[20]) vb = -vb;
    bad = 0;
    r = 0;
    case (op)
      4'd10: r = va + vb;
      4'd11: r = va - vb;
      4'd12: r = va * vb;
      4'd13: if (vb == 0) bad = 1; else r = va / vb;
      default: bad = 1;
    endcase
    if (r > 99999 || r < -99999) bad = 1;
    if (bad) return {1'b1, 21'd0};
    return {1'b0, r < 0, int2bcd(r < 0 ? -r : r)};
  endfunction

  // 0 means latency not fixed for this operation
  function automatic int lat_of(logic [3:0] op, logic [20:0] b);
    if (op == 4'd10 || op == 4'd11) return 7;
    if (op == 4'd13) return (b[19:0] == 20'd0) ? 2 : 0;
    if (op == 4'd12) return 0;
    return 2;
  endfunction

  function automatic logic [20:0] rand_word();
    logic [20:0] v = '0;
    int nd = $urandom_range(1, 5);
    for (int k = 0; k < nd; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
    v[20] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_accept(logic [20:0] a, logic [20:0] b, logic [3:0] op);
    BCDa = a; BCDb = b; opcode = op; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    start_cyc = cyc;
    exp_q.push_back(model(a, b, op));
    lat_q.push_back(lat_of(op, b));
    acc_cnt++;
    BCDa = rand_word(); BCDb = rand_word(); opcode = 4'($urandom_range(0, 15));
  endtask

  task automatic issue(logic [20:0] a, logic [20:0] b, logic [3:0] op);
    @(posedge clk); #2;
    drive_accept(a, b, op);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout waiting for done, pending %0d", exp_q.size());
      exp_q.delete(); lat_q.delete();
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic [21:0] mon_e;
  int          mon_l;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done result %h err %b", result, err);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          check("result", 32'(result), 32'(mon_e[20:0]));
          check("err", 32'(err), 32'(mon_e[21]));
          check("busy_at_done", 32'(busy), 32'd0);
          if (mon_l != 0) check("latency", 32'(cyc - start_cyc), 32'(mon_l));
        end
      end else if (exp_q.size() != 0) begin
        check("busy_during_op", 32'(busy), 32'd1);
      end
    end
  end

  // ---------------- directed vectors with hand-computed results ----------------
  localparam int ND = 11;
  logic [20:0] dir_a [ND] = '{21'h000123, 21'h000005, 21'h000007, 21'h000250, 21'h050000,
                              21'h099999, 21'h000007, 21'h100007, 21'h000100, 21'h000003,
                              21'h100300};
  logic [20:0] dir_b [ND] = '{21'h000456, 21'h000009, 21'h000007, 21'h100004, 21'h000002,
                              21'h000001, 21'h000002, 21'h000002, 21'h000000, 21'h000009,
                              21'h000100};
  logic [3:0]  dir_op[ND] = '{4'd10, 4'd11, 4'd11, 4'd12, 4'd12, 4'd10, 4'd14, 4'd13,
                              4'd13, 4'd13, 4'd10};
  logic [21:0] dir_x [ND] = '{22'h000579, 22'h100004, 22'h000000, 22'h101000, 22'h200000,
                              22'h200000, 22'h200000, 22'h100003, 22'h200000, 22'h000000,
                              22'h100200};

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "simulation time limit");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // directed: pin the model, then run the DUT against it
    for (int i = 0; i < ND; i++) begin
      check($sformatf("model_pin_%0d", i), 32'(model(dir_a[i], dir_b[i], dir_op[i])),
            32'(dir_x[i]));
      wait_idle();
      issue(dir_a[i], dir_b[i], dir_op[i]);
    end
    wait_idle();

    // back-to-back: second start in the cycle done is high
    issue(21'h000123, 21'h000456, 4'd10);
    repeat (7) @(posedge clk);
    #2;
    drive_accept(21'h100050, 21'h000020, 4'd11);
    wait_idle();

    // start pulses while busy must be ignored
    issue(21'h000123, 21'h000456, 4'd12);
    for (int i = 0; i < 3; i++) begin
      repeat (10) @(posedge clk);
      #2;
      BCDa = rand_word(); BCDb = rand_word(); opcode = 4'd10; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
    end
    wait_idle();
    repeat (20) @(posedge clk);

    // reset in the middle of a multiply
    issue(21'h099999, 21'h099999, 4'd12);
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete(); lat_q.delete();
    acc_cnt--;
    #1;
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    check("after_rst_state", 32'(dbg_state), 32'd0);
    issue(21'h000123, 21'h000456, 4'd10);
    wait_idle();

    // randomized operations
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(10, 13)) : 4'($urandom_range(0, 15));
      issue(rand_word(), rand_word(), op);
      wait_idle();
    end

    repeat (20) @(posedge clk);
    check("done_count", 32'(done_cnt), 32'(acc_cnt));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: BCDa  input  21  operand A; bit 20 = sign (1 = negative), bits 19:0 = five packed BCD digits.
REQ-004 SHALL: BCDb  input  21  operand B, same format as BCDa.
REQ-005 SHALL: opcode  input  4  10 add, 11 sub, 12 mul, 13 div; other values are illegal.
REQ-006 SHALL: start  input  1  request pulse, sampled only in IDLE.
REQ-007 SHALL: result  output  21  signed BCD result, same format as the operands.
REQ-008 SHALL: busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL: done  output  1  one-cycle completion pulse.
REQ-010 SHALL: err  output  1  overflow, divide-by-zero or illegal-opcode flag, valid while done is high.

Function
REQ-011 SHALL: start is accepted only in IDLE; BCDa, BCDb and opcode are captured on that edge, and later input changes have no effect.
REQ-012 SHALL: start while busy is ignored and is not queued.
REQ-013 SHALL: FSM states are IDLE, SETUP, ADDSUB, MUL_SHIFT, MUL_ADD, DIV_SHIFT, DIV_CMP, DIV_SUB, DONE.
REQ-014 SHALL: SETUP computes magnitudes |A| and |B|, the effective operation and the result sign in one cycle.
REQ-015 SHALL: magnitude compare is done on the packed BCD value, which is monotonic like binary.
REQ-016 SHALL: add/sub with equal effective signs adds the magnitudes; with unequal signs it subtracts the smaller magnitude from the larger and takes the sign of the larger.
REQ-017 SHALL: add/sub processes one digit per cycle, LSD first, over 5 cycles; done is asserted exactly 7 cycles after the start-sampling edge.
REQ-018 SHALL: mul iterates B digits MSD to LSD; for each digit the accumulator shifts left one digit (MUL_SHIFT), then |A| is added B_i times, each addition being a 5-cycle digit-serial pass (MUL_ADD).
REQ-019 SHALL: mul raises overflow when a nonzero digit 4 is shifted out or when an addition carries out of digit 4.
REQ-020 SHALL: mul result sign = signA xor signB.
REQ-021 SHALL: div is restoring and truncates toward zero; per A digit (MSD first) R = R*10 + A_i, then |B| is subtracted while R >= |B| (1-cycle compare, 5-cycle subtract), and the subtraction count becomes Q_i.
REQ-022 SHALL: div result sign = signA xor signB.
REQ-023 SHALL: |B| = 0 on div skips computation, and done asserts 2 cycles after start is sampled with err = 1.
REQ-024 SHALL: an illegal opcode gives done 2 cycles after start is sampled, with err = 1.
REQ-025 SHALL: on err, result is forced to 0 with sign 0.
REQ-026 SHALL: a zero magnitude result always carries sign 0; there is no -0.
REQ-027 SHALL: result and err update on the same edge that raises done, and hold until the next done.
REQ-028 SHALL: busy deasserts on the edge that raises done; a new start may be sampled in the cycle done is high.

Reset
REQ-029 SHALL: reset asynchronously forces IDLE, result = 0, busy = 0, done = 0, err = 0, and clears all internal accumulators and counters.
REQ-030 SHALL: reset asserted mid-operation aborts it with no done pulse; the first start after reset release is processed normally.

Structure
REQ-031 SHALL: shared package calc_pkg holds the opcode constants (OP_ADD = 10, OP_SUB = 11, OP_MUL = 12, OP_DIV = 13), NDIG = 5, WORD_W = 21 and the FSM state encoding.
REQ-032 SHALL: one combinational sub-module, bcd_digit_addsub, is the only digit arithmetic unit (4-bit digit in A and B, carry/borrow in, mode add/sub; digit out, carry/borrow out), and it is time-shared by all operations.

Verification
REQ-033 SHALL: add: A = +00123, B = +00456, op 10 -> result +00579, err 0, done 7 cycles after start.
REQ-034 SHALL: sub: A = +00005, B = +00009, op 11 -> result bit 20 = 1 and magnitude 00004; A = +00007, B = +00007 -> +00000.
REQ-035 SHALL: mul: A = +00250, B = -00004, op 12 -> -01000; A = 50000, B = 00002 -> err 1, result 0.
REQ-036 SHALL: overflow and illegal opcode: 99999 + 00001 -> err 1, result 0; opcode 14 -> err 1, done 2 cycles after start.
REQ-037 SHALL: div: -00007 / +00002 -> -00003; 00100 / 00000 -> err 1 with done 2 cycles after start; 00003 / 00009 -> +00000.
REQ-038 SHALL: control: rst_n pulsed low mid-mul -> no done pulse, all outputs 0; start pulsed while busy is ignored; back-to-back start in the done cycle is accepted.
